// File: rtl/serial_word_feeder_pkg.sv
// serial_word_feeder_pkg
// Shared definitions for the serial word feeder: the FSM state encoding,
// the width of the completed-word counter, and a helper that works out how
// many bits go on the serial line per word.
// No ports (package).
package serial_word_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  localparam int WORDS_SENT_W = 16;

  // Bits per word on the line: the data bits, plus one when a parity bit
  // trails the LSB.
  function automatic int line_bits(input int width, input bit parity);
    return parity ? width + 1 : width;
  endfunction

endpackage

// File: rtl/serial_word_feeder_piso_shift_reg.sv
// piso_shift_reg
// Parallel-in, serial-out register. It loads a WIDTH-bit word, shifts left
// by one bit per enabled cycle with zeros entering at the LSB, and taps the
// MSB. Once the whole word has been shifted out the register holds zero, so
// the tap idles low without any extra gating.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-low clear
//   load  - load din (takes priority over shift)
//   shift - shift left by one
//   din   - parallel word to load
//   msb   - current MSB (the serial bit)
module piso_shift_reg
  import serial_word_feeder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/serial_word_feeder.sv
// serial_word_feeder
// Takes WIDTH-bit words over a valid/ready handshake and sends them MSB
// first, one bit per clock, on a single serial line. Between words the line
// sits at 0. After each word the feeder can insert GAP idle cycles.
// Optional feature macro: FEEDER_PARITY_EN. When it is defined, an even-parity
// bit (the XOR of the word) follows the LSB.
// Parameters:
//   WIDTH - word width, 2..32
//   GAP   - idle cycles after each word, 0..15
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-low reset
//   data_in    - parallel word, sampled on acceptance
//   data_valid - upstream offers data_in
//   data_ready - feeder can accept this cycle (from state/counter only)
//   out        - registered serial bit
//   out_valid  - registered; out carries a word bit
//   busy       - in SHIFT or GAP
//   words_sent - count of completed words, wraps at 16 bits
module serial_word_feeder
  import serial_word_feeder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic                    out,
  output logic                    out_valid,
  output logic                    busy,
  output logic [WORDS_SENT_W-1:0] words_sent
);

`ifdef FEEDER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int               NBITS    = line_bits(WIDTH, PARITY_EN);
  localparam int               CNT_W    = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NBITS - 1);
  localparam bit               HAS_GAP  = (GAP > 0);
  localparam logic [3:0]       GAP_LOAD = HAS_GAP ? 4'(GAP - 1) : 4'd0;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;
  logic [NBITS-1:0] payload;
  logic             last_bit;
  logic             accept;
  logic             shift_en;

`ifdef FEEDER_PARITY_EN
  assign payload = {data_in, ^data_in};
`else
  assign payload = data_in;
`endif

  // The last bit of a word is on the line while the counter reads zero.
  // With no gap configured, the feeder is ready again in that same cycle,
  // which lets words run back to back.
  assign last_bit   = (state == ST_SHIFT) && (bit_cnt == '0);
  assign data_ready = (state == ST_IDLE) || (last_bit && !HAS_GAP);
  assign accept     = data_valid && data_ready;
  assign busy       = (state != ST_IDLE);

  // A reload on the last-bit edge replaces the shift. Otherwise the final
  // shift empties the register, so out returns to 0.
  assign shift_en = (state == ST_SHIFT) && !accept;

  piso_shift_reg #(
    .WIDTH(NBITS)
  ) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .shift(shift_en),
    .din  (payload),
    .msb  (out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt == '0) begin
          if (HAS_GAP) begin
            state_nxt = ST_GAP;
          end else if (accept) begin
            state_nxt = ST_SHIFT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == 4'd0) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt   <= '0;
      gap_cnt   <= 4'd0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        bit_cnt <= CNT_LOAD;
      end else if ((state == ST_SHIFT) && (bit_cnt != '0)) begin
        bit_cnt <= bit_cnt - CNT_W'(1);
      end

      if (last_bit && HAS_GAP) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == ST_GAP) && (gap_cnt != 4'd0)) begin
        gap_cnt <= gap_cnt - 4'd1;
      end

      if (accept) begin
        out_valid <= 1'b1;
      end else if (last_bit) begin
        out_valid <= 1'b0;
      end
    end
  end

  // A word counts as sent on the edge that ends its last-bit cycle. A word
  // cut short by reset is never counted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      words_sent <= '0;
    end else if (last_bit) begin
      words_sent <= words_sent + WORDS_SENT_W'(1);
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// tb_serial_word_feeder
// Directed bench for serial_word_feeder. dut_a is built with WIDTH=8, GAP=0.
// dut_b is built with WIDTH=8, GAP=3. Expected bit streams are worked out
// from the words in the bench. When FEEDER_PARITY_EN is defined, each word
// is followed by an even-parity bit.
module tb_serial_word_feeder;

`ifdef FEEDER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [7:0]  di_a = 8'h00;
  logic        dv_a = 1'b0;
  logic        rdy_a;
  logic        out_a;
  logic        ov_a;
  logic        busy_a;
  logic [15:0] ws_a;

  logic [7:0]  di_b = 8'h00;
  logic        dv_b = 1'b0;
  logic        rdy_b;
  logic        out_b;
  logic        ov_b;
  logic        busy_b;
  logic [15:0] ws_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_word_feeder #(.WIDTH(8), .GAP(0)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .data_in   (di_a),
    .data_valid(dv_a),
    .data_ready(rdy_a),
    .out       (out_a),
    .out_valid (ov_a),
    .busy      (busy_a),
    .words_sent(ws_a)
  );

  serial_word_feeder #(.WIDTH(8), .GAP(3)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .data_in   (di_b),
    .data_valid(dv_b),
    .data_ready(rdy_b),
    .out       (out_b),
    .out_valid (ov_b),
    .busy      (busy_b),
    .words_sent(ws_b)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit i of the line image of word w: data MSB first, then the parity bit.
  function automatic logic exp_bit(input logic [7:0] w, input int i);
    if (i < 8) return w[7 - i];
    return ^w;
  endfunction

  // Offer one word to dut_a for one cycle. On return it has been accepted,
  // and the first bit is on the line.
  task automatic apply_stimulus(input logic [7:0] w);
    @(negedge clk);
    dv_a = 1'b1;
    di_a = w;
    @(negedge clk);
    dv_a = 1'b0;
  endtask

  initial begin
    logic [7:0] w;

    // Reset state
    repeat (2) @(negedge clk);
    check_output("rst_out", out_a, 1'b0);
    check_output("rst_out_valid", ov_a, 1'b0);
    check_output("rst_busy", busy_a, 1'b0);
    check_output("rst_words", ws_a, 16'd0);
    check_output("rst_ready", rdy_a, 1'b1);
    check_output("rst_ready_b", rdy_b, 1'b1);
    rst = 1'b1;

    // Single word 8'h96
    apply_stimulus(8'h96);
    check_output("single_ready_busy", rdy_a, 1'b0);
    for (int i = 0; i < NB; i++) begin
      check_output($sformatf("single_bit%0d", i), out_a, exp_bit(8'h96, i));
      check_output($sformatf("single_valid%0d", i), ov_a, 1'b1);
      @(negedge clk);
    end
    check_output("single_idle_out", out_a, 1'b0);
    check_output("single_idle_valid", ov_a, 1'b0);
    check_output("single_words", ws_a, 16'd1);
    check_output("single_ready", rdy_a, 1'b1);
    check_output("single_busy", busy_a, 1'b0);

    // Reset in the middle of 8'hF0
    apply_stimulus(8'hF0);
    check_output("midrst_bit0", out_a, 1'b1);
    repeat (2) @(negedge clk);
    check_output("midrst_bit2", out_a, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_output("midrst_out", out_a, 1'b0);
    check_output("midrst_valid", ov_a, 1'b0);
    check_output("midrst_words", ws_a, 16'd0);
    check_output("midrst_busy", busy_a, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst_ready_after", rdy_a, 1'b1);
    check_output("midrst_valid_after", ov_a, 1'b0);

    // Back-to-back 8'h99 then 8'h09 with data_valid held high
    dv_a = 1'b1;
    di_a = 8'h99;
    for (int k = 0; k < 2 * NB; k++) begin
      @(negedge clk);
      w = (k < NB) ? 8'h99 : 8'h09;
      check_output($sformatf("b2b_bit%0d", k), out_a, exp_bit(w, k % NB));
      check_output($sformatf("b2b_valid%0d", k), ov_a, 1'b1);
      if (k == 0) begin
        check_output("b2b_ready_first", rdy_a, 1'b0);
        di_a = 8'h09;
      end
      if (k == NB - 1) check_output("b2b_ready_last", rdy_a, 1'b1);
      if (k == NB) dv_a = 1'b0;
    end
    @(negedge clk);
    check_output("b2b_end_valid", ov_a, 1'b0);
    check_output("b2b_words", ws_a, 16'd2);

    // 8'h07 (parity bit 1 when the parity bit is enabled)
    apply_stimulus(8'h07);
    for (int i = 0; i < NB; i++) begin
      check_output($sformatf("p07_bit%0d", i), out_a, exp_bit(8'h07, i));
      check_output($sformatf("p07_valid%0d", i), ov_a, 1'b1);
      @(negedge clk);
    end
    check_output("p07_end_valid", ov_a, 1'b0);
    check_output("p07_words", ws_a, 16'd3);

    // GAP=3 on dut_b, two words offered continuously
    dv_b = 1'b1;
    di_b = 8'hA5;
    for (int k = 0; k < 2 * NB + 4; k++) begin
      @(negedge clk);
      if (k < NB) begin
        check_output($sformatf("gap_w1_bit%0d", k), out_b, exp_bit(8'hA5, k));
        check_output($sformatf("gap_w1_valid%0d", k), ov_b, 1'b1);
      end else if (k < NB + 3) begin
        check_output($sformatf("gap_out%0d", k), out_b, 1'b0);
        check_output($sformatf("gap_valid%0d", k), ov_b, 1'b0);
        check_output($sformatf("gap_ready%0d", k), rdy_b, 1'b0);
        check_output($sformatf("gap_busy%0d", k), busy_b, 1'b1);
      end else if (k == NB + 3) begin
        check_output("gap_idle_ready", rdy_b, 1'b1);
        check_output("gap_idle_valid", ov_b, 1'b0);
        check_output("gap_idle_busy", busy_b, 1'b0);
      end else begin
        check_output($sformatf("gap_w2_bit%0d", k), out_b, exp_bit(8'h3C, k - NB - 4));
        check_output($sformatf("gap_w2_valid%0d", k), ov_b, 1'b1);
      end
      if (k == 0) di_b = 8'h3C;
      if (k == NB + 4) dv_b = 1'b0;
    end
    @(negedge clk);
    check_output("gap_end_valid", ov_b, 1'b0);
    check_output("gap_words", ws_b, 16'd2);

    // Wrap of words_sent from 16'hFFFF
    @(negedge clk);
    force dut_a.words_sent = 16'hFFFF;
    #1;
    release dut_a.words_sent;
    apply_stimulus(8'h01);
    repeat (NB) @(negedge clk);
    check_output("wrap_words", ws_a, 16'd0);
    check_output("wrap_valid", ov_a, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
